// File: rtl/adaptive_filter_ctrl.sv
// adaptive_filter_ctrl: frame sequencer for the LMS filter (shift, MAC, settle, capture, weight update).
module adaptive_filter_ctrl #(
    parameter int TAPS       = 16,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             abort,
    input  logic             clr_ovr,
    output logic             shift_en,
    output logic             filt_en,
    output logic [3:0]       tap_idx,
    output logic             err_capture,
    output logic             upd_en,
    output logic [3:0]       upd_idx,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             overrun
);
    localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    localparam logic [3:0] LAST = 4'(TAPS - 1);
    localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC - 1);
    typedef enum logic [2:0] {IDLE, SHIFT, FILTER, SETTLE, CAPTURE, UPDATE, DONE} state_t;
    state_t state;
    logic [SW-1:0] scnt;
    assign sample_ready = (state == IDLE) && !abort && !rst;
    // Outputs are loaded on the edge that enters the state they belong to, so each is a clean register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            scnt        <= '0;
            shift_en    <= 1'b0;
            filt_en     <= 1'b0;
            tap_idx     <= 4'd0;
            err_capture <= 1'b0;
            upd_en      <= 1'b0;
            upd_idx     <= 4'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            overrun     <= 1'b0;
        end else begin
            overrun     <= (sample_valid && state != IDLE) || (overrun && !clr_ovr);
            shift_en    <= 1'b0;
            err_capture <= 1'b0;
            frame_done  <= 1'b0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                filt_en <= 1'b0;
                upd_en  <= 1'b0;
                tap_idx <= 4'd0;
                upd_idx <= 4'd0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (sample_valid && sample_ready) begin
                        state    <= SHIFT;
                        shift_en <= 1'b1;
                        busy     <= 1'b1;
                    end
                    SHIFT: begin
                        state   <= FILTER;
                        filt_en <= 1'b1;
                    end
                    FILTER: if (tap_idx == LAST) begin
                        state <= SETTLE;
                        scnt  <= '0;
                    end else tap_idx <= tap_idx + 4'd1;
                    SETTLE: if (scnt == SLAST) begin
                        state       <= CAPTURE;
                        filt_en     <= 1'b0;
                        tap_idx     <= 4'd0;
                        err_capture <= 1'b1;
                    end else scnt <= scnt + SW'(1);
                    CAPTURE: begin
                        state  <= UPDATE;
                        upd_en <= 1'b1;
                    end
                    UPDATE: if (upd_idx == LAST) begin
                        state      <= DONE;
                        upd_en     <= 1'b0;
                        upd_idx    <= 4'd0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                    end else upd_idx <= upd_idx + 4'd1;
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adaptive_filter_ctrl.sv
// tb_adaptive_filter_ctrl: directed vector bench for the frame sequencer (4-bit frame counter build).
module tb_adaptive_filter_ctrl;
    localparam int CW = 4;
    logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0, abort = 1'b0, clr_ovr = 1'b0;
    logic sample_ready, shift_en, filt_en, err_capture, upd_en, busy, frame_done, overrun;
    logic [3:0] tap_idx, upd_idx;
    logic [CW-1:0] frame_cnt;
    int n_chk = 0, n_fail = 0;

    adaptive_filter_ctrl #(.TAPS(16), .SETTLE_CYC(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .abort(abort), .clr_ovr(clr_ovr), .shift_en(shift_en), .filt_en(filt_en),
        .tap_idx(tap_idx), .err_capture(err_capture), .upd_en(upd_en), .upd_idx(upd_idx),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       shift, filt;
        logic [3:0] tap;
        logic       cap, upd;
        logic [3:0] uidx;
        logic       bsy, done, rdy;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] obs();
        return {shift_en, filt_en, tap_idx, err_capture, upd_en, upd_idx, busy, frame_done, sample_ready};
    endfunction

    task automatic run_frame(input logic [CW-1:0] exp_cnt);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("run_shift", 32'(shift_en), 1);
        repeat (36) step();
        chk("run_done", 32'(frame_done), 1);
        chk("run_cnt", 32'(frame_cnt), 32'(exp_cnt));
        step();
        chk("run_idle", 32'(busy), 0);
    endtask

    initial begin
        int cur, shifts, dones, strobes;
        tbl[0]  = '{1,  1, 0, 4'd0,  0, 0, 4'd0,  1, 0, 0};
        tbl[1]  = '{2,  0, 1, 4'd0,  0, 0, 4'd0,  1, 0, 0};
        tbl[2]  = '{3,  0, 1, 4'd1,  0, 0, 4'd0,  1, 0, 0};
        tbl[3]  = '{17, 0, 1, 4'd15, 0, 0, 4'd0,  1, 0, 0};
        tbl[4]  = '{18, 0, 1, 4'd15, 0, 0, 4'd0,  1, 0, 0};
        tbl[5]  = '{19, 0, 1, 4'd15, 0, 0, 4'd0,  1, 0, 0};
        tbl[6]  = '{20, 0, 0, 4'd0,  1, 0, 4'd0,  1, 0, 0};
        tbl[7]  = '{21, 0, 0, 4'd0,  0, 1, 4'd0,  1, 0, 0};
        tbl[8]  = '{22, 0, 0, 4'd0,  0, 1, 4'd1,  1, 0, 0};
        tbl[9]  = '{30, 0, 0, 4'd0,  0, 1, 4'd9,  1, 0, 0};
        tbl[10] = '{36, 0, 0, 4'd0,  0, 1, 4'd15, 1, 0, 0};
        tbl[11] = '{37, 0, 0, 4'd0,  0, 0, 4'd0,  1, 1, 0};
        tbl[12] = '{38, 0, 0, 4'd0,  0, 0, 4'd0,  0, 0, 1};

        // reset state
        #12;
        chk("reset_outputs", 32'(obs()), 0);
        chk("reset_cnt", 32'(frame_cnt), 0);
        chk("reset_ovr", 32'(overrun), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_reset", 32'(sample_ready), 1);

        // single frame against the vector table
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        cur = 1;
        foreach (tbl[r]) begin
            while (cur < tbl[r].cyc) begin
                step();
                cur++;
            end
            chk($sformatf("frame@k+%0d", tbl[r].cyc), 32'(obs()),
                32'({tbl[r].shift, tbl[r].filt, tbl[r].tap, tbl[r].cap, tbl[r].upd,
                     tbl[r].uidx, tbl[r].bsy, tbl[r].done, tbl[r].rdy}));
            if (tbl[r].cyc == 37) chk("frame_cnt_1", 32'(frame_cnt), 1);
        end
        chk("single_no_ovr", 32'(overrun), 0);

        // back-to-back frames with valid held
        sample_valid = 1'b1;
        shifts = 0;
        dones = 0;
        for (int i = 1; i <= 190; i++) begin
            step();
            if (shift_en) begin
                chk("b2b_accept_cycle", 32'(i), 32'(1 + 38 * shifts));
                shifts++;
            end
            if (frame_done) dones++;
        end
        sample_valid = 1'b0;
        chk("b2b_accepts", 32'(shifts), 5);
        chk("b2b_dones", 32'(dones), 5);
        chk("b2b_cnt", 32'(frame_cnt), 6);
        chk("b2b_ovr", 32'(overrun), 1);
        #1 chk("b2b_idle_ready", 32'(sample_ready), 1);

        // clr_ovr alone in IDLE
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);

        // set beats clear, then abort during FILTER
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (3) step();
        sample_valid = 1'b1;
        clr_ovr = 1'b1;
        step();
        sample_valid = 1'b0;
        clr_ovr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 1);
        repeat (5) step();
        chk("pre_abort_filt", 32'(filt_en), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1 chk("abort_idle", 32'(obs()), 1);
        chk("abort_cnt", 32'(frame_cnt), 6);
        strobes = 0;
        repeat (40) begin
            step();
            if (err_capture || frame_done || shift_en || upd_en) strobes++;
        end
        chk("abort_no_strobes", 32'(strobes), 0);
        run_frame(CW'(7));

        // abort together with valid in IDLE
        abort = 1'b1;
        sample_valid = 1'b1;
        #1 chk("abort_blocks_ready", 32'(sample_ready), 0);
        step();
        chk("abort_no_shift", 32'({shift_en, busy}), 0);
        abort = 1'b0;
        #1 chk("ready_after_abort", 32'(sample_ready), 1);
        step();
        sample_valid = 1'b0;
        chk("late_accept", 32'(shift_en), 1);
        repeat (36) step();
        chk("late_done", 32'(frame_done), 1);
        chk("late_cnt", 32'(frame_cnt), 8);
        step();

        // counter wrap on the 4-bit build
        for (int f = 9; f <= 15; f++) run_frame(CW'(f));
        run_frame(CW'(0));

        // async reset during UPDATE
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (24) step();
        chk("pre_rst_upd", 32'({upd_en, upd_idx}), 32'({1'b1, 4'd4}));
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", 32'(obs()), 0);
        chk("async_rst_state", 32'({frame_cnt, overrun}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_rst", 32'(sample_ready), 1);
        step();
        chk("idle_after_rst", 32'({busy, shift_en}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adaptive_filter_ctrl.md
# adaptive_filter_ctrl

Frame sequencer for the 16-tap LMS adaptive filter datapath. It accepts one input sample per frame through a valid/ready handshake and shifts it into the delay line. It then runs the filter MAC pass over all taps, waits for the error result to settle, strobes error capture, and runs the per-tap weight-update pass. It is the only block that drives the filter's run enable and the weight-update enables.

## Interface
Parameters:
- TAPS, 16, taps per frame; sets FILTER and UPDATE phase lengths (index ports are 4 bits, so TAPS ≤ 16)
- SETTLE_CYC, 2, cycles filter run enable stays high after the last MAC tap, so d/e can settle
- CNT_W, 16, frame counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- sample_valid  in  1  new input sample available
- sample_ready  out  1  controller can accept a sample
- abort  in  1  synchronous frame abort
- clr_ovr  in  1  clears overrun flag
- shift_en  out  1  one-cycle push of the new sample into the delay line
- filt_en  out  1  filter run enable (datapath adap_filter_state)
- tap_idx  out  4  current MAC tap during FILTER
- err_capture  out  1  one-cycle strobe: latch error e
- upd_en  out  1  weight-update write enable
- upd_idx  out  4  weight index being updated
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at the end of a complete frame
- frame_cnt  out  CNT_W  completed-frame count
- overrun  out  1  sticky: a sample was offered while busy

## Operation
- States: IDLE → SHIFT → FILTER → SETTLE → CAPTURE → UPDATE → DONE → IDLE.
- All outputs are registered Moore outputs, except sample_ready.
- sample_ready = (state==IDLE) & ~abort & ~rst (combinational).
- A sample is accepted on a rising edge with sample_valid & sample_ready. The next state is SHIFT.
- SHIFT: shift_en=1 for 1 cycle.
- FILTER: filt_en=1 for TAPS cycles; tap_idx counts 0..TAPS-1, one per cycle.
- SETTLE: filt_en=1 for SETTLE_CYC cycles; tap_idx holds TAPS-1.
- CAPTURE: err_capture=1 for 1 cycle; filt_en=0.
- UPDATE: upd_en=1 for TAPS cycles; upd_idx counts 0..TAPS-1.
- DONE: frame_done=1 for 1 cycle; frame_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
- tap_idx and upd_idx read 0 outside their own phases.
- abort in any non-IDLE state: next state is IDLE and all enables/strobes are 0 from the next cycle. No frame_done, frame_cnt unchanged, partial update not replayed.
- abort in IDLE: forces sample_ready low, so a simultaneous sample_valid is not accepted.
- overrun is set when sample_valid=1 and state≠IDLE. It is cleared by clr_ovr. If set and clear occur in the same cycle, set wins.
- overrun does not affect sequencing. A sample offered while busy is not accepted. Upstream must hold it until sample_ready.

## Timing
- Reset (async, any time, including mid-frame):
  - state IDLE;
  - shift_en, filt_en, err_capture, upd_en, frame_done, busy, overrun = 0;
  - tap_idx = upd_idx = 0, frame_cnt = 0;
  - sample_ready = 0 while rst is high and 1 on the first cycle after release.
- Accept edge = cycle k. Defaults TAPS=16, SETTLE_CYC=2:
  - SHIFT at k+1
  - FILTER at k+2..k+17
  - SETTLE at k+18..k+19
  - CAPTURE at k+20
  - UPDATE at k+21..k+36
  - DONE at k+37
  - IDLE at k+38, sample_ready=1 again
- Frame period = TAPS*2 + SETTLE_CYC + 4 cycles = 38 cycles.
- Back-to-back frames: sample_valid held high → accepts at k and k+38.
- busy=1 from k+1 through k+37 inclusive.

## Test plan
- Reset, then sample_valid=1 for one cycle in IDLE:
  - shift_en at k+1;
  - filt_en high k+2..k+19 (18 cycles), tap_idx 0..15 then holds 15;
  - err_capture at k+20;
  - upd_en high k+21..k+36, upd_idx 0..15;
  - frame_done at k+37; frame_cnt=1.
- sample_valid held high for 200 cycles: accepts at k, k+38, k+76, k+114, k+152; frame_cnt=5 after the fifth DONE; overrun=1 (valid seen while busy).
- abort at k+10 (FILTER): filt_en=0 and IDLE at k+11; no err_capture, no frame_done; frame_cnt unchanged; next sample accepted at k+11 if valid.
- abort and sample_valid together in IDLE: sample_ready=0, no shift_en next cycle; sample is accepted the following cycle once abort drops.
- overrun set and clr_ovr in the same cycle → overrun stays 1. clr_ovr alone in IDLE → overrun 0.
- Preload via 65535 frames (or a CNT_W=4 build: 15 frames), run one more: frame_cnt wraps to 0. Assert rst at k+25 (UPDATE): all outputs 0 asynchronously, sample_ready=1 on the first cycle after release.
